sd_cmd_tx: RTL
==============

# sd_cmd_tx

- Serializer for SD-card command frames on the CMD line.
- Accepts a 6-bit command index and a 32-bit argument, then drives the 48-bit frame MSB-first: start bit 0, transmission bit 1, index, argument, CRC7, end bit 1.
- Computes CRC7 (x^7 + x^3 + 1) bit-serially over the first 40 frame bits and generates the SD clock.
- Sits between the SD host controller FSM and the CMD pad; the response path (CRC7 checker) is downstream on the same line.

## Interface
- CLK_DIV, 4: system clocks per SD bit period; even, ≥2.
- GAP_BITS, 8: bit periods of idle SD clocking after the end bit (Ncc).
- CLK  in  1  system clock, all logic on rising edge.
- NRESET  in  1  reset; synchronous and active-low.
- START  in  1  one-cycle request; sampled only when BUSY=0.
- CMD_INDEX  in  6  command index, captured on accepted START.
- CMD_ARG  in  32  argument, captured on accepted START.
- BUSY  out  1  frame or gap in progress.
- DONE  out  1  one-cycle pulse at end of gap.
- CRC_SENT  out  7  CRC7 transmitted; valid from DONE until next accepted START.
- SD_CLK  out  1  SD card clock.
- SD_CMD_OUT  out  1  CMD line data.
- SD_CMD_OE  out  1  CMD line output enable.

## Operation
- States: IDLE, FRAME, CRC, END, GAP.
- IDLE
  - START=1 loads a 40-bit shift register with {0,1,CMD_INDEX,CMD_ARG}, clears the CRC register to 0 and enters FRAME.
- FRAME: 40 bit periods.
  - Each bit period drives shreg[39]; at the end of the period the CRC updates with it and shreg shifts left.
  - CRC update: inv=bit^crc[6]; crc <= {crc[5:3], crc[2]^inv, crc[1:0], inv}.
- CRC: 7 bit periods driving crc[6] first (crc shifts left, no feedback). CRC_SENT latched on entry.
- END: 1 bit period, SD_CMD_OUT=1.
- GAP
  - GAP_BITS periods with SD_CMD_OE=0, SD_CMD_OUT=1 and SD_CLK still toggling.
  - Then DONE=1, BUSY=0, back to IDLE.
- START while BUSY=1 is ignored; no queueing.
- START in the DONE cycle is ignored; it is accepted from the following cycle.
- CMD_INDEX/CMD_ARG changes after acceptance do not affect the frame in flight.

## Timing
- Reset values (NRESET low at a CLK edge): state IDLE, BUSY=0, DONE=0, SD_CLK=0, SD_CMD_OUT=1, SD_CMD_OE=0, CRC_SENT=0, divider=0.
- Reset mid-frame aborts at the next edge with the same values. The partial frame is not resumed.
- START accepted at edge t:
  - From t+1: BUSY=1, SD_CMD_OE=1, SD_CMD_OUT=0 (start bit).
  - Each bit is held exactly CLK_DIV cycles.
- SD_CLK in each bit period: low for the first CLK_DIV/2 cycles, high for the rest. The card samples on the rising edge mid-bit, and data changes only while SD_CLK is low.
- SD_CMD_OE falls at t+1+48·CLK_DIV.
- DONE is high in cycle t+1+(48+GAP_BITS)·CLK_DIV; BUSY is low in that same cycle.
- In IDLE, SD_CLK is held at 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package sd_pkg holds:
  - state enum and frame constants: FRAME_BITS=48, PAYLOAD_BITS=40, CRC_BITS=7;
  - start/transmission bit values.
- One sub-module: sd_crc7_ser.
  - Clock-enabled serial CRC7 with synchronous clear.
  - Ports: CLK, NRESET, CLR, EN, BIT, CRC[6:0].
  - Reusable by the response checker.
- Bit-period divider and bit counter (6 bits) live in sd_cmd_tx.

## Test plan
- CMD0, arg 0x00000000 → serial frame 0x40_0000_0000_95, CRC_SENT=0x4A, DONE at t+1+56·CLK_DIV.
- CMD17, arg 0x00000000 → frame 0x51_0000_0000_55, CRC_SENT=0x2A.
- CMD8, arg 0x000001AA → frame 0x48_0000_01AA_87, CRC_SENT=0x43.
- START pulsed again at bit 20 of a CMD0 frame, with CMD_ARG changed after acceptance → frame unchanged, exactly one DONE.
- NRESET low during CRC phase → next cycle SD_CMD_OE=0, SD_CMD_OUT=1, BUSY=0. A following CMD0 still yields CRC 0x4A.
- CLK_DIV=2, GAP_BITS=0, back-to-back CMD0 with START in the cycle after DONE → second frame starts 2 cycles after DONE, SD_CLK pattern 0,1 per bit.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command path: FSM states, frame geometry
// and fixed framing bits.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_CRC,
        ST_END,
        ST_GAP
    } sd_state_e;

    localparam int unsigned FRAME_BITS   = 48;
    localparam int unsigned PAYLOAD_BITS = 40;
    localparam int unsigned CRC_BITS     = 7;

    localparam logic START_BIT_VAL = 1'b0;
    localparam logic TX_BIT_VAL    = 1'b1;
    localparam logic END_BIT_VAL   = 1'b1;

endpackage

// File: rtl/sd_crc7_ser.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) with clock enable and synchronous clear;
// shared by the command transmitter and the response checker.
module sd_crc7_ser (
    input  logic       CLK,
    input  logic       NRESET,
    input  logic       CLR,
    input  logic       EN,
    input  logic       BIT,
    output logic [6:0] CRC
);

    logic [6:0] crc_q, crc_d;
    logic       inv;

    always_comb begin
        crc_d = crc_q;
        inv   = BIT ^ crc_q[6];
        if (CLR) begin
            crc_d = '0;
        end else if (EN) begin
            crc_d = {crc_q[5:3], crc_q[2] ^ inv, crc_q[1:0], inv};
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRESET) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign CRC = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command-frame serializer: shifts start/tx/index/arg, appends CRC7 and
// end bit, then clocks GAP_BITS idle periods; generates SD_CLK throughout.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned GAP_BITS = 8
) (
    input  logic        CLK,
    input  logic        NRESET,
    input  logic        START,
    input  logic [5:0]  CMD_INDEX,
    input  logic [31:0] CMD_ARG,
    output logic        BUSY,
    output logic        DONE,
    output logic [6:0]  CRC_SENT,
    output logic        SD_CLK,
    output logic        SD_CMD_OUT,
    output logic        SD_CMD_OE
);

    localparam int unsigned DIV_W       = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [5:0] PAY_LAST     = 6'(PAYLOAD_BITS - 1);
    localparam logic [5:0] CRC_LAST     = 6'(PAYLOAD_BITS + CRC_BITS - 1);
    localparam logic [5:0] GAP_LAST     = 6'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    sd_state_e          state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [39:0]        shreg_q, shreg_d;
    logic [6:0]         crc_sh_q, crc_sh_d;
    logic [6:0]         crc_sent_q, crc_sent_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sd_clk_q, sd_clk_d;
    logic               cmd_out_q, cmd_out_d;
    logic               cmd_oe_q, cmd_oe_d;

    logic               period_end;
    logic               crc_clr, crc_en;
    logic [6:0]         crc_w;

    sd_crc7_ser u_crc (
        .CLK    (CLK),
        .NRESET (NRESET),
        .CLR    (crc_clr),
        .EN     (crc_en),
        .BIT    (shreg_q[39]),
        .CRC    (crc_w)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        crc_sh_d   = crc_sh_q;
        crc_sent_d = crc_sent_q;
        done_d     = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        period_end = (div_q == DIV_LAST);

        if (state_q != ST_IDLE) begin
            div_d = period_end ? '0 : div_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (START && !done_q) begin
                    state_d   = ST_FRAME;
                    shreg_d   = {START_BIT_VAL, TX_BIT_VAL, CMD_INDEX, CMD_ARG};
                    bit_cnt_d = '0;
                    crc_clr   = 1'b1;
                end
            end
            ST_FRAME: begin
                // CRC absorbs the bit at the start of its period so the final
                // value is already registered when the CRC phase is entered.
                crc_en = (div_q == '0);
                if (period_end) begin
                    shreg_d   = {shreg_q[38:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == PAY_LAST) begin
                        state_d    = ST_CRC;
                        crc_sh_d   = crc_w;
                        crc_sent_d = crc_w;
                    end
                end
            end
            ST_CRC: begin
                if (period_end) begin
                    crc_sh_d  = {crc_sh_q[5:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CRC_LAST) begin
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (period_end) begin
                    bit_cnt_d = '0;
                    if (GAP_BITS == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (period_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from next-state values so every pin is a flop.
        busy_d    = (state_d != ST_IDLE);
        cmd_oe_d  = (state_d == ST_FRAME) || (state_d == ST_CRC) || (state_d == ST_END);
        sd_clk_d  = (state_d != ST_IDLE) && (div_d >= DIV_HALF);
        case (state_d)
            ST_FRAME: cmd_out_d = shreg_d[39];
            ST_CRC:   cmd_out_d = crc_sh_d[6];
            ST_END:   cmd_out_d = END_BIT_VAL;
            default:  cmd_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRESET) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            crc_sh_q   <= '0;
            crc_sent_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sd_clk_q   <= 1'b0;
            cmd_out_q  <= 1'b1;
            cmd_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            crc_sh_q   <= crc_sh_d;
            crc_sent_q <= crc_sent_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sd_clk_q   <= sd_clk_d;
            cmd_out_q  <= cmd_out_d;
            cmd_oe_q   <= cmd_oe_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign CRC_SENT   = crc_sent_q;
    assign SD_CLK     = sd_clk_q;
    assign SD_CMD_OUT = cmd_out_q;
    assign SD_CMD_OE  = cmd_oe_q;

endmodule
